// File: rtl/key_schedule_cd.sv
// key_schedule_cd: DES key schedule C/D register (PC-1 load, per-round rotations) with valid/ready handshakes.
// Optional build macro DES_KEY_DECRYPT_EN adds decrypt_i and the right-rotating decryption order.
module key_schedule_cd (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:64] key_i,
   input  logic        key_valid_i,
   output logic        key_ready_o,
   output logic [1:56] cd_o,
   output logic        cd_valid_o,
   input  logic        cd_ready_i,
   output logic [3:0]  round_o,
   output logic        done_o
`ifdef DES_KEY_DECRYPT_EN
   ,
   input  logic        decrypt_i
`endif
);
   typedef enum logic {IDLE, ROUND} state_t;
   state_t      state_q, state_d;
   logic [1:56] cd_q, cd_d, cd0;
   logic [3:0]  round_q, round_d;
   logic        done_q, done_d;
   logic        accept, xfer, single, unused_parity;
`ifdef DES_KEY_DECRYPT_EN
   logic        dec_q, dec_d;
`endif
   function automatic logic [1:28] rotl(input logic [1:28] h, input logic one);
      return one ? {h[2:28], h[1]} : {h[3:28], h[1:2]};
   endfunction
`ifdef DES_KEY_DECRYPT_EN
   function automatic logic [1:28] rotr(input logic [1:28] h, input logic one);
      return one ? {h[28], h[1:27]} : {h[27:28], h[1:26]};
   endfunction
`endif
   // PC-1: C half from the first 28 table entries, D half from the last 28; parity bits never selected
   assign cd0 = {key_i[57], key_i[49], key_i[41], key_i[33], key_i[25], key_i[17], key_i[9],
                 key_i[1],  key_i[58], key_i[50], key_i[42], key_i[34], key_i[26], key_i[18],
                 key_i[10], key_i[2],  key_i[59], key_i[51], key_i[43], key_i[35], key_i[27],
                 key_i[19], key_i[11], key_i[3],  key_i[60], key_i[52], key_i[44], key_i[36],
                 key_i[63], key_i[55], key_i[47], key_i[39], key_i[31], key_i[23], key_i[15],
                 key_i[7],  key_i[62], key_i[54], key_i[46], key_i[38], key_i[30], key_i[22],
                 key_i[14], key_i[6],  key_i[61], key_i[53], key_i[45], key_i[37], key_i[29],
                 key_i[21], key_i[13], key_i[5],  key_i[28], key_i[20], key_i[12], key_i[4]};
   assign unused_parity = ^{key_i[8], key_i[16], key_i[24], key_i[32],
                            key_i[40], key_i[48], key_i[56], key_i[64]};
   assign accept = state_q == IDLE && key_valid_i;
   assign xfer   = state_q == ROUND && cd_ready_i;
   // Single-bit steps fall on transfers from rounds 0, 7 and 14 in both directions; 15 only matters for decrypt
   assign single = round_q == 4'd0 || round_q == 4'd7 || round_q == 4'd14 || round_q == 4'd15;
   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cd_q    <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
`ifdef DES_KEY_DECRYPT_EN
         dec_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         round_q <= round_d;
         done_q  <= done_d;
`ifdef DES_KEY_DECRYPT_EN
         dec_q   <= dec_d;
`endif
      end
   end
   // Next state: a key starts a schedule, the round-15 transfer ends it
   always_comb begin
      state_d = accept ? ROUND : (xfer && round_q == 4'd15) ? IDLE : state_q;
   end
   // Datapath next values: load on acceptance, rotate on each transfer; CD16 equals CD0 so encrypt holds at 15
   always_comb begin
      cd_d    = cd_q;
      round_d = round_q;
      done_d  = xfer && round_q == 4'd15;
`ifdef DES_KEY_DECRYPT_EN
      dec_d   = dec_q;
      if (accept) begin
         dec_d   = decrypt_i;
         cd_d    = decrypt_i ? cd0 : {rotl(cd0[1:28], 1'b1), rotl(cd0[29:56], 1'b1)};
         round_d = 4'd0;
      end else if (xfer) begin
         round_d = round_q + 4'd1;
         cd_d    = dec_q ? {rotr(cd_q[1:28], single), rotr(cd_q[29:56], single)} :
                   round_q == 4'd15 ? cd_q : {rotl(cd_q[1:28], single), rotl(cd_q[29:56], single)};
      end
`else
      if (accept) begin
         cd_d    = {rotl(cd0[1:28], 1'b1), rotl(cd0[29:56], 1'b1)};
         round_d = 4'd0;
      end else if (xfer) begin
         round_d = round_q + 4'd1;
         cd_d    = round_q == 4'd15 ? cd_q : {rotl(cd_q[1:28], single), rotl(cd_q[29:56], single)};
      end
`endif
   end
   // Handshake outputs decoded from state
   always_comb begin
      key_ready_o = state_q == IDLE;
      cd_valid_o  = state_q == ROUND;
   end
   assign cd_o    = cd_q;
   assign round_o = round_q;
   assign done_o  = done_q;
endmodule

// File: tb/tb_key_schedule_cd.sv
// tb_key_schedule_cd: directed checks of the DES C/D key schedule against the textbook example key.
module tb_key_schedule_cd;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:64] key_i = '0;
   logic        key_valid_i = 1'b0;
   logic        key_ready_o;
   logic [1:56] cd_o;
   logic        cd_valid_o;
   logic        cd_ready_i = 1'b0;
   logic [3:0]  round_o;
   logic        done_o;
`ifdef DES_KEY_DECRYPT_EN
   logic        decrypt_i = 1'b0;
`endif
   int checks = 0;
   int errors = 0;
   localparam logic [1:64] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [1:64] KEY_P = 64'h123556789ABDDEF0;
   localparam logic [1:64] KEY_B = 64'h0123456789ABCDEF;
   logic [55:0] exp_cd [16] = '{
      56'hE19955F_AACCF1E, 56'hC332ABF_5599E3D, 56'h0CCAAFF_56678F5, 56'h332ABFC_599E3D5,
      56'hCCAAFF0_6678F55, 56'h32ABFC3_99E3D55, 56'hCAAFF0C_678F556, 56'h2ABFC33_9E3D559,
      56'h557F866_3C7AAB3, 56'h55FE199_F1EAACC, 56'h57F8665_C7AAB33, 56'h5FE1995_1EAACCF,
      56'h7F86655_7AAB33C, 56'hFE19955_EAACCF1, 56'hF866557_AAB33C7, 56'hF0CCAAF_556678F};

   key_schedule_cd dut (
      .clk(clk), .rst_n(rst_n), .key_i(key_i), .key_valid_i(key_valid_i),
      .key_ready_o(key_ready_o), .cd_o(cd_o), .cd_valid_o(cd_valid_o),
      .cd_ready_i(cd_ready_i), .round_o(round_o), .done_o(done_o)
`ifdef DES_KEY_DECRYPT_EN
      , .decrypt_i(decrypt_i)
`endif
   );

   always #5 clk = ~clk;

   task automatic start_key(input logic [1:64] k);
      key_i = k;
      key_valid_i = 1'b1;
      @(negedge clk);
      key_valid_i = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      checks++; if (key_ready_o !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b exp 1", key_ready_o); end
      checks++; if (cd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_cd_valid got %b exp 0", cd_valid_o); end
      checks++; if (cd_o !== 56'h0) begin errors++; $display("FAIL reset_cd got %h exp 0", cd_o); end
      checks++; if (round_o !== 4'd0) begin errors++; $display("FAIL reset_round got %0d exp 0", round_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (key_ready_o !== 1'b1 || cd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_release got ready=%b valid=%b exp ready=1 valid=0", key_ready_o, cd_valid_o); end
   endtask

   task automatic test_encrypt;
      cd_ready_i = 1'b1;
      start_key(KEY_A);
      for (int r = 0; r < 16; r++) begin
         checks++; if (cd_valid_o !== 1'b1 || key_ready_o !== 1'b0) begin errors++; $display("FAIL enc_handshake r=%0d got valid=%b ready=%b exp valid=1 ready=0", r, cd_valid_o, key_ready_o); end
         checks++; if (round_o !== 4'(r)) begin errors++; $display("FAIL enc_round got %0d exp %0d", round_o, r); end
         checks++; if (cd_o !== exp_cd[r]) begin errors++; $display("FAIL enc_cd r=%0d got %h exp %h", r, cd_o, exp_cd[r]); end
         checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL enc_done_early r=%0d got %b exp 0", r, done_o); end
         @(negedge clk);
      end
      checks++; if (done_o !== 1'b1 || key_ready_o !== 1'b1 || cd_valid_o !== 1'b0) begin errors++; $display("FAIL enc_done got done=%b ready=%b valid=%b exp 1 1 0", done_o, key_ready_o, cd_valid_o); end
      checks++; if (cd_o !== exp_cd[15]) begin errors++; $display("FAIL enc_final_cd got %h exp %h", cd_o, exp_cd[15]); end
      @(negedge clk);
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL enc_done_pulse got %b exp 0", done_o); end
   endtask

   task automatic test_backpressure;
      cd_ready_i = 1'b1;
      start_key(KEY_A);
      for (int r = 0; r < 3; r++) begin
         checks++; if (cd_o !== exp_cd[r] || round_o !== 4'(r)) begin errors++; $display("FAIL bp_pre r=%0d got %h/%0d exp %h/%0d", r, cd_o, round_o, exp_cd[r], r); end
         @(negedge clk);
      end
      cd_ready_i = 1'b0;
      repeat (5) begin
         @(negedge clk);
         checks++; if (cd_o !== exp_cd[3] || round_o !== 4'd3 || cd_valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold got %h/%0d/%b exp %h/3/1", cd_o, round_o, cd_valid_o, exp_cd[3]); end
      end
      cd_ready_i = 1'b1;
      @(negedge clk);
      for (int r = 4; r < 16; r++) begin
         checks++; if (cd_o !== exp_cd[r] || round_o !== 4'(r)) begin errors++; $display("FAIL bp_resume r=%0d got %h/%0d exp %h/%0d", r, cd_o, round_o, exp_cd[r], r); end
         @(negedge clk);
      end
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", done_o); end
      @(negedge clk);
   endtask

   task automatic test_ignore_key;
      cd_ready_i = 1'b1;
      start_key(KEY_A);
      for (int r = 0; r < 16; r++) begin
         if (r == 2) begin key_i = KEY_B; key_valid_i = 1'b1; end
         if (r == 15) key_valid_i = 1'b0;
         checks++; if (cd_o !== exp_cd[r] || key_ready_o !== 1'b0) begin errors++; $display("FAIL ign_cd r=%0d got %h ready=%b exp %h ready=0", r, cd_o, key_ready_o, exp_cd[r]); end
         @(negedge clk);
      end
      checks++; if (done_o !== 1'b1 || cd_o !== exp_cd[15]) begin errors++; $display("FAIL ign_done got done=%b cd=%h exp 1 %h", done_o, cd_o, exp_cd[15]); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      cd_ready_i = 1'b1;
      start_key(KEY_A);
      repeat (16) @(negedge clk);
      checks++; if (done_o !== 1'b1 || key_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_done got done=%b ready=%b exp 1 1", done_o, key_ready_o); end
      start_key(KEY_P);
      for (int r = 0; r < 16; r++) begin
         checks++; if (cd_o !== exp_cd[r] || round_o !== 4'(r) || cd_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_parity_cd r=%0d got %h/%0d/%b exp %h/%0d/1", r, cd_o, round_o, cd_valid_o, exp_cd[r], r); end
         @(negedge clk);
      end
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", done_o); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      cd_ready_i = 1'b1;
      start_key(KEY_A);
      repeat (7) @(negedge clk);
      checks++; if (round_o !== 4'd7) begin errors++; $display("FAIL rst_mid_pre got %0d exp 7", round_o); end
      rst_n = 1'b0;
      #1;
      checks++; if (cd_valid_o !== 1'b0 || round_o !== 4'd0 || cd_o !== 56'h0 || done_o !== 1'b0) begin errors++; $display("FAIL rst_mid got valid=%b round=%0d cd=%h done=%b exp 0 0 0 0", cd_valid_o, round_o, cd_o, done_o); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (key_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_release got %b exp 1", key_ready_o); end
      @(negedge clk);
      checks++; if (cd_valid_o !== 1'b0 || cd_o !== 56'h0) begin errors++; $display("FAIL rst_mid_idle got valid=%b cd=%h exp 0 0", cd_valid_o, cd_o); end
   endtask

`ifdef DES_KEY_DECRYPT_EN
   task automatic test_decrypt;
      cd_ready_i = 1'b1;
      decrypt_i = 1'b1;
      start_key(KEY_A);
      decrypt_i = 1'b0;
      for (int r = 0; r < 16; r++) begin
         checks++; if (cd_o !== exp_cd[15-r] || round_o !== 4'(r)) begin errors++; $display("FAIL dec_cd r=%0d got %h/%0d exp %h/%0d", r, cd_o, round_o, exp_cd[15-r], r); end
         @(negedge clk);
      end
      checks++; if (done_o !== 1'b1 || cd_o !== exp_cd[15]) begin errors++; $display("FAIL dec_done got done=%b cd=%h exp 1 %h", done_o, cd_o, exp_cd[15]); end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset;
      test_encrypt;
      test_backpressure;
      test_ignore_key;
      test_back_to_back;
`ifdef DES_KEY_DECRYPT_EN
      test_decrypt;
`endif
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
